regfile_wb_arbiter: RTL and testbench

// - Shares the single register-file write port between the in-order pipeline WB stage and a

---
 rtl/cpu_defs.sv | 30 +++
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/wb_pend_queue.sv | 94 +++++++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Package     : cpu_defs
// Description : Shared register-file widths, the zero-register address and
//               the write-back entry record used by the WB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // One queued register write; dead entries are kept only to be popped
   typedef struct packed {
      logic              live;
      logic [REG_AW-1:0] wa;
      logic [REG_DW-1:0] wd;
   } wb_entry_t;

   // One-hot decode of a register address into a per-register mask
   function automatic logic [2**REG_AW-1:0] reg_onehot(input logic [REG_AW-1:0] wa);
      logic [2**REG_AW-1:0] m;
      m     = '0;
      m[wa] = 1'b1;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : regfile_wb_arbiter_if
// Description : Pipeline WB, secondary writer and regfile write-port signals
//               of the WB arbiter, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if
   import cpu_defs::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          p_we;
   logic [AW-1:0] p_wa;
   logic [DW-1:0] p_wd;
   logic          s_valid;
   logic          s_ready;
   logic [AW-1:0] s_wa;
   logic [DW-1:0] s_wd;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic [2**AW-1:0] pending_mask;
   logic [CW-1:0] q_count;

   // Producer side: pipeline, secondary writer and observers of the port
   modport master (
      output p_we, p_wa, p_wd, s_valid, s_wa, s_wd,
      input  s_ready, rf_we, rf_wa, rf_wd, pending_mask, q_count
   );

   // Arbiter side
   modport slave (
      input  p_we, p_wa, p_wd, s_valid, s_wa, s_wd,
      output s_ready, rf_we, rf_wa, rf_wd, pending_mask, q_count
   );

endinterface
`default_nettype wire

// File: rtl/wb_pend_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_pend_queue
// Description : Small FIFO of pending secondary register writes. Exposes the
//               head, per-entry live/address for hazard masks, and kills live
//               entries matching a squash address.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pend_queue
   import cpu_defs::*;
#(
   parameter int DEPTH = 4
)(
   input  wire logic                            clk,
   input  wire logic                            rst,
   input  wire logic                            push,
   input  wire wb_entry_t                       push_entry,
   input  wire logic                            pop,
   input  wire logic                            squash_en,
   input  wire logic [REG_AW-1:0]               squash_wa,
   output wb_entry_t                            head,
   output logic                                 head_valid,
   output logic                                 full,
   output logic [$clog2(DEPTH):0]               count,
   output logic [DEPTH-1:0]                     ent_live,
   output logic [DEPTH-1:0][REG_AW-1:0]         ent_wa
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] c_ptr_one = 1;

   logic [PW:0]        r_wr_ptr;
   logic [PW:0]        r_rd_ptr;
   logic [DEPTH-1:0]   r_valid;
   logic [DEPTH-1:0]   r_live;
   logic [REG_AW-1:0]  r_wa [DEPTH];
   logic [REG_DW-1:0]  r_wd [DEPTH];

   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
   assign count     = r_wr_ptr - r_rd_ptr;
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !w_empty;

   assign head_valid = !w_empty;
   assign head.live  = r_live[r_rd_ptr[PW-1:0]];
   assign head.wa    = r_wa[r_rd_ptr[PW-1:0]];
   assign head.wd    = r_wd[r_rd_ptr[PW-1:0]];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
         assign ent_live[gi] = r_valid[gi] && r_live[gi];
         assign ent_wa[gi]   = r_wa[gi];
      end
   endgenerate

   // Pointers, occupancy and liveness; squash only kills entries already held
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_valid  <= '0;
         r_live   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && r_valid[i] && r_live[i] && (r_wa[i] == squash_wa)) begin
               r_live[i] <= 1'b0;
            end
         end
         if (w_do_pop) begin
            r_valid[r_rd_ptr[PW-1:0]] <= 1'b0;
            r_rd_ptr                  <= r_rd_ptr + c_ptr_one;
         end
         if (w_do_push) begin
            r_valid[r_wr_ptr[PW-1:0]] <= 1'b1;
            r_live[r_wr_ptr[PW-1:0]]  <= push_entry.live;
            r_wr_ptr                  <= r_wr_ptr + c_ptr_one;
         end
      end
   end

   // Entry payload; meaningless while the slot is invalid, so no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push && !rst) begin
         r_wa[r_wr_ptr[PW-1:0]] <= push_entry.wa;
         r_wd[r_wr_ptr[PW-1:0]] <= push_entry.wd;
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the regfile write port between the pipeline WB stage
//               (always wins, zero latency) and a queued secondary writer that
//               drains in idle cycles. Exports a pending-write mask for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
   import cpu_defs::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW
)(
   input  wire logic             clk,
   input  wire logic             rst,
   regfile_wb_arbiter_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t                    w_head;
   wb_entry_t                    w_push_entry;
   logic                         w_head_valid;
   logic                         w_full;
   logic [CW-1:0]                w_count;
   logic [DEPTH-1:0]             w_ent_live;
   logic [DEPTH-1:0][REG_AW-1:0] w_ent_wa;
   logic                         w_p_act;
   logic                         w_head_write;
   logic                         w_pop;
   logic                         w_push;
   logic                         w_rf_we;
   logic [AW-1:0]                w_rf_wa;
   logic [DW-1:0]                w_rf_wd;
   logic [2**AW-1:0]             w_mask;

   // Writes to r0 are architecturally void, so they never claim the port.
   assign w_p_act = bus.p_we && (bus.p_wa != REG_ZERO);

   // Queue writes are suppressed while rst is high so a reset mid-drain lets
   // no queued value reach the regfile in the reset cycle itself.
   assign w_head_write = w_head_valid && w_head.live && !w_p_act && !rst;
   assign w_pop        = w_head_valid && !w_p_act && !rst;
   assign w_push       = bus.s_valid && !w_full;

   assign w_push_entry.live = (bus.s_wa != REG_ZERO);
   assign w_push_entry.wa   = bus.s_wa;
   assign w_push_entry.wd   = bus.s_wd;

   wb_pend_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push),
      .push_entry (w_push_entry),
      .pop        (w_pop),
      .squash_en  (w_p_act),
      .squash_wa  (bus.p_wa),
      .head       (w_head),
      .head_valid (w_head_valid),
      .full       (w_full),
      .count      (w_count),
      .ent_live   (w_ent_live),
      .ent_wa     (w_ent_wa)
   );

   // Write-port priority mux: pipeline, then live queue head, else idle
   always_comb begin
      w_rf_we = 1'b0;
      w_rf_wa = '0;
      w_rf_wd = '0;
      if (w_p_act) begin
         w_rf_we = 1'b1;
         w_rf_wa = bus.p_wa;
         w_rf_wd = bus.p_wd;
      end else if (w_head_write) begin
         w_rf_we = 1'b1;
         w_rf_wa = w_head.wa;
         w_rf_wd = w_head.wd;
      end
   end

   // Pending mask: OR of one-hot destinations of live queued entries
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_ent_live[i]) begin
            w_mask = w_mask | reg_onehot(w_ent_wa[i]);
         end
      end
      w_mask[0] = 1'b0;
   end

   assign bus.rf_we        = w_rf_we;
   assign bus.rf_wa        = w_rf_wa;
   assign bus.rf_wd        = w_rf_wd;
   assign bus.s_ready      = !w_full;
   assign bus.pending_mask = w_mask;
   assign bus.q_count      = w_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter: directed scenarios
//               with literal expectations plus randomized traffic compared each
//               cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
   import cpu_defs::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   regfile_wb_arbiter_if #(.DEPTH(DEPTH), .AW(REG_AW), .DW(REG_DW)) bus ();

   regfile_wb_arbiter #(
      .DEPTH (DEPTH),
      .AW    (REG_AW),
      .DW    (REG_DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the queue contents as a plain list of entries
   wb_entry_t mq[$];
   bit        chk_en = 1'b0;

   // Model update at each active edge
   initial begin
      forever begin
         int        old_size;
         bit        pact;
         wb_entry_t e;
         @(posedge clk);
         if (rst) begin
            mq.delete();
            chk_en = 1'b1;
         end else begin
            old_size = mq.size();
            pact     = bus.p_we && (bus.p_wa != 0);
            if (pact) begin
               for (int i = 0; i < mq.size(); i++) begin
                  e = mq[i];
                  if (e.live && e.wa == bus.p_wa) begin
                     e.live = 1'b0;
                     mq[i]  = e;
                  end
               end
            end
            if (!pact && old_size > 0) void'(mq.pop_front());
            if (bus.s_valid && old_size < DEPTH) begin
               e.live = (bus.s_wa != 0);
               e.wa   = bus.s_wa;
               e.wd   = bus.s_wd;
               mq.push_back(e);
            end
         end
      end
   end

   // Compare DUT outputs against the model away from the active edge
   initial begin
      forever begin
         logic              x_we;
         logic [REG_AW-1:0] x_wa;
         logic [REG_DW-1:0] x_wd;
         logic [31:0]       x_mask;
         @(negedge clk);
         if (chk_en) begin
            x_we = 1'b0; x_wa = '0; x_wd = '0; x_mask = '0;
            if (bus.p_we && bus.p_wa != 0) begin
               x_we = 1'b1; x_wa = bus.p_wa; x_wd = bus.p_wd;
            end else if (!rst && mq.size() > 0 && mq[0].live) begin
               x_we = 1'b1; x_wa = mq[0].wa; x_wd = mq[0].wd;
            end
            foreach (mq[i]) if (mq[i].live) x_mask[mq[i].wa] = 1'b1;
            check("m_rf_we",   bus.rf_we,        x_we);
            check("m_rf_wa",   bus.rf_wa,        x_wa);
            check("m_rf_wd",   bus.rf_wd,        x_wd);
            check("m_s_ready", bus.s_ready,      (mq.size() < DEPTH));
            check("m_mask",    bus.pending_mask, x_mask);
            check("m_q_count", bus.q_count,      mq.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.p_we = 1'b0; bus.p_wa = '0; bus.p_wd = '0;
      bus.s_valid = 1'b0; bus.s_wa = '0; bus.s_wd = '0;
   endtask

   initial begin
      int idx;
      // Reset held two cycles with a request pending
      idle();
      rst = 1'b1;
      bus.s_valid = 1'b1; bus.s_wa = 5'd4; bus.s_wd = 32'h1234;
      tick(); tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("rst_we", bus.rf_we, 0);
      check("rst_ready", bus.s_ready, 1);
      check("rst_mask", bus.pending_mask, 0);
      check("rst_qcount", bus.q_count, 0);
      tick();

      // Idle drain of a single secondary write
      bus.s_valid = 1'b1; bus.s_wa = 5'd5; bus.s_wd = 32'hDEADBEEF;
      tick();
      idle();
      @(negedge clk);
      check("drain_we", bus.rf_we, 1);
      check("drain_wa", bus.rf_wa, 5);
      check("drain_wd", bus.rf_wd, 32'hDEADBEEF);
      check("drain_mask5", bus.pending_mask[5], 1);
      tick();
      @(negedge clk);
      check("drain_mask_clr", bus.pending_mask, 0);
      check("drain_qcount", bus.q_count, 0);
      check("drain_we_off", bus.rf_we, 0);
      tick();

      // Contention: pipeline holds the port while r7..r11 are offered
      idx = 0;
      for (int k = 0; k < 8; k++) begin
         bus.p_we = 1'b1; bus.p_wa = 5'd3; bus.p_wd = 32'h33 + k;
         bus.s_valid = 1'b1; bus.s_wa = 5'(7 + idx); bus.s_wd = 32'h100 + idx;
         @(negedge clk);
         check("cont_we", bus.rf_we, 1);
         check("cont_wa", bus.rf_wa, 3);
         if (k == 4) begin
            check("cont_full_ready", bus.s_ready, 0);
            check("cont_full_qcount", bus.q_count, 4);
         end
         if (bus.s_ready) idx++;
         tick();
      end
      check("cont_accepted", idx, 4);
      bus.p_we = 1'b0; bus.p_wa = '0; bus.p_wd = '0;
      for (int j = 0; j < 5; j++) begin
         bus.s_valid = (idx < 5); bus.s_wa = 5'(7 + idx); bus.s_wd = 32'h100 + idx;
         @(negedge clk);
         check("cont_drain_we", bus.rf_we, 1);
         check("cont_drain_wa", bus.rf_wa, 7 + j);
         if (bus.s_ready && bus.s_valid) idx++;
         tick();
      end
      idle();
      @(negedge clk);
      check("cont_r11_taken", idx, 5);
      check("cont_empty", bus.q_count, 0);
      tick();

      // Squash: queued r9 overtaken by a pipeline write to r9
      bus.p_we = 1'b1; bus.p_wa = 5'd3; bus.p_wd = 32'h44;
      bus.s_valid = 1'b1; bus.s_wa = 5'd9; bus.s_wd = 32'h1;
      tick();
      bus.s_valid = 1'b0; bus.p_wa = 5'd9; bus.p_wd = 32'h2;
      @(negedge clk);
      check("sq_wa", bus.rf_wa, 9);
      check("sq_wd", bus.rf_wd, 2);
      check("sq_mask_before", bus.pending_mask[9], 1);
      tick();
      idle();
      @(negedge clk);
      check("sq_mask_after", bus.pending_mask[9], 0);
      check("sq_dead_qcount", bus.q_count, 1);
      check("sq_dead_we", bus.rf_we, 0);
      tick();
      @(negedge clk);
      check("sq_popped", bus.q_count, 0);
      check("sq_idle_we", bus.rf_we, 0);
      tick();

      // Zero register: dead entry drains without a write
      bus.s_valid = 1'b1; bus.s_wa = 5'd0; bus.s_wd = 32'h55;
      tick();
      idle();
      @(negedge clk);
      check("z_qcount1", bus.q_count, 1);
      check("z_we", bus.rf_we, 0);
      tick();
      @(negedge clk);
      check("z_qcount0", bus.q_count, 0);
      check("z_we2", bus.rf_we, 0);
      // Pipeline write to r0 does not block the dead head from draining
      bus.p_we = 1'b1; bus.p_wa = 5'd3; bus.p_wd = 32'h66;
      bus.s_valid = 1'b1; bus.s_wa = 5'd0;
      tick();
      bus.s_valid = 1'b0; bus.p_wa = 5'd0; bus.p_wd = 32'h77;
      @(negedge clk);
      check("zp_we", bus.rf_we, 0);
      check("zp_qcount", bus.q_count, 1);
      tick();
      idle();
      @(negedge clk);
      check("zp_drained", bus.q_count, 0);
      tick();

      // Reset mid-operation with three entries queued
      bus.p_we = 1'b1; bus.p_wa = 5'd3; bus.p_wd = 32'h88;
      for (int k = 0; k < 3; k++) begin
         bus.s_valid = 1'b1; bus.s_wa = 5'(12 + k); bus.s_wd = 32'h200 + k;
         tick();
      end
      idle();
      rst = 1'b1;
      @(negedge clk);
      check("rm_rst_we", bus.rf_we, 0);
      check("rm_rst_qcount", bus.q_count, 3);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rm_we", bus.rf_we, 0);
         check("rm_qcount", bus.q_count, 0);
         check("rm_mask", bus.pending_mask, 0);
         check("rm_ready", bus.s_ready, 1);
         tick();
      end

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         rst         = ($urandom_range(0, 63) == 0);
         bus.p_we    = 1'($urandom_range(0, 1));
         bus.p_wa    = 5'($urandom_range(0, 15));
         bus.p_wd    = $urandom;
         bus.s_valid = ($urandom_range(0, 9) < 6);
         bus.s_wa    = 5'($urandom_range(0, 15));
         bus.s_wd    = $urandom;
         tick();
      end
      rst = 1'b0;
      idle();
      for (int c = 0; c < 6; c++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
